// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing stage: serialises start, LSB-first data, optional parity and stop bits.
// TX_OUT and busy are registered from the next-state decode, so they follow an accept by one cycle.
module uart_tx_frame_ctrl #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 CLK_PAR,
    input  logic                 RST_PAR,
    input  logic [DATA_SIZE-1:0] P_DATA_SER,
    input  logic                 Data_valid_SER,
    input  logic                 PAR_EN_SER,
    input  logic                 par_bit_SER,
    output logic                 TX_OUT,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    // Handshake: a word is taken on any edge where Data_valid_SER=1 and the FSM is IDLE;
    // busy=1 tells the source that Data_valid_SER is ignored until busy drops again.

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_SIZE-1:0] shreg_q, shreg_d;
    logic                 par_en_q, par_en_d;
    logic                 par_q, par_d;
    logic                 tx_d, busy_d;
    logic                 last_tick;
    logic                 bit_end;

    always_ff @(posedge CLK_PAR or negedge RST_PAR) begin
        if (!RST_PAR) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            TX_OUT   <= tx_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_d     = par_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        bit_end   = 1'b0;
        last_tick = (tick_q == LAST_TICK);

        case (state_q)
            S_IDLE: begin
                if (Data_valid_SER) begin
                    state_d  = S_START;
                    shreg_d  = P_DATA_SER;
                    par_en_d = PAR_EN_SER;
                end
            end
            S_START: begin
                // Parity calculator registered the accepted word on the accept edge.
                if (tick_q == '0) par_d = par_bit_SER;
                if (last_tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = shreg_q >> 1;
                        bit_end = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (last_tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (last_tick) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || bit_end) tick_d = '0;
        else if (state_q != S_IDLE)          tick_d = tick_q + TW'(1);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign dbg_state = state_q;

endmodule
